// File: rtl/dcache_ctrl_if.sv
// Memory-side bus of the MEM-stage data cache: a registered request held until a
// one-cycle acknowledge pulse, carrying either a line fill or a write-through store.
interface dcache_ctrl_if;
    logic             mem_req;
    logic             mem_we;
    logic [29:0]      mem_addr;
    logic [3:0]       mem_be;
    logic [0:3][7:0]  mem_wdata;
    logic [0:3][7:0]  mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-byte lines.
// Freezes the pipeline while a line fill or a write-through is outstanding.
module dcache_ctrl #(
    parameter int INDEX_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [0:3][7:0]  wdata,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             is_LB_SB,
    output logic [0:3][7:0]  cache_data_out,
    output logic             freeze,
    dcache_ctrl_if.master    bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t state;
    state_t next_state;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [0:3][7:0]       data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   addr_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  ack;
    logic                  start_req;
    logic                  start_we;
    logic                  fill_done;
    logic                  write_hit;

    assign idx       = addr[INDEX_BITS+1:2];
    assign addr_tag  = addr[31:INDEX_BITS+2];
    // Fill placement comes from the held request address, not the pipeline address.
    assign fill_idx  = bus.mem_addr[INDEX_BITS-1:0];
    assign fill_tag  = bus.mem_addr[29:INDEX_BITS];
    assign hit       = valid[idx] && (tag_mem[idx] == addr_tag);
    assign ack       = bus.mem_req && bus.mem_ack;
    assign fill_done = (state == FILL) && ack;
    assign write_hit = (state == IDLE) && mem_write && hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        freeze         = 1'b0;
        cache_data_out = '0;
        start_req      = 1'b0;
        start_we       = 1'b0;
        case (state)
            IDLE: begin
                if (mem_write) begin
                    freeze     = 1'b1;
                    start_req  = 1'b1;
                    start_we   = 1'b1;
                    next_state = WRITE;
                end else if (mem_read) begin
                    if (hit) begin
                        cache_data_out = data_mem[idx];
                    end else begin
                        freeze     = 1'b1;
                        start_req  = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                freeze = 1'b1;
                if (ack) next_state = DONE;
            end
            WRITE: begin
                freeze = 1'b1;
                if (ack) next_state = DONE;
            end
            DONE: begin
                // One unfrozen cycle so the instruction still in MEM cannot re-trigger.
                if (mem_read && !mem_write) cache_data_out = data_mem[idx];
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
        end else if (start_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= start_we;
            bus.mem_addr  <= addr[31:2];
            bus.mem_be    <= start_we ? (is_LB_SB ? (4'b0001 << addr[1:0]) : 4'hF) : 4'h0;
            bus.mem_wdata <= start_we ? wdata : '0;
        end else if (ack) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.mem_rdata;
        end else if (write_hit) begin
            if (is_LB_SB) begin
                data_mem[idx][addr[1:0]] <= wdata[addr[1:0]];
            end else begin
                data_mem[idx] <= wdata;
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a hand-driven memory responder acknowledges after a
// chosen number of request cycles, and every expected value is written out by hand.
module tb_dcache_ctrl;
    logic             clk;
    logic             rst;
    logic [31:0]      addr;
    logic [0:3][7:0]  wdata;
    logic             mem_read;
    logic             mem_write;
    logic             is_LB_SB;
    logic [0:3][7:0]  cache_data_out;
    logic             freeze;

    int compared;
    int mismatched;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.INDEX_BITS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .wdata          (wdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .is_LB_SB       (is_LB_SB),
        .cache_data_out (cache_data_out),
        .freeze         (freeze),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic byte_op,
                                 input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        mem_read  = rd;
        mem_write = wr;
        is_LB_SB  = byte_op;
        addr      = a;
        wdata     = wd;
    endtask

    // Runs one MEM-stage access to completion, acking on the given request cycle;
    // returns at the negedge of the first unfrozen cycle (hit cycle or DONE).
    task automatic service(input string tag, input int ack_after, input logic [31:0] rd,
                           output int freeze_cycles, output int req_first, output logic we_seen,
                           output logic [29:0] addr_seen, output logic [3:0] be_seen,
                           output logic [31:0] wd_seen);
        int   req_cycles;
        int   iter;
        logic done;
        req_cycles    = 0;
        iter          = 0;
        done          = 1'b0;
        freeze_cycles = 0;
        req_first     = 0;
        we_seen       = 1'b0;
        addr_seen     = '0;
        be_seen       = '0;
        wd_seen       = '0;
        while (!done && iter < 40) begin
            iter++;
            @(negedge clk);
            if (!freeze) begin
                done = 1'b1;
            end else begin
                freeze_cycles++;
                if (bus.mem_req) begin
                    req_cycles++;
                    if (req_cycles == 1) begin
                        req_first = freeze_cycles;
                        we_seen   = bus.mem_we;
                        addr_seen = bus.mem_addr;
                        be_seen   = bus.mem_be;
                        wd_seen   = bus.mem_wdata;
                    end
                    if (req_cycles == ack_after) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = rd;
                    end
                end
                @(posedge clk);
                #1;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = '0;
            end
        end
        checkOutput({tag, "_timeout"}, {63'd0, !done}, 64'd0);
    endtask

    int          fc;
    int          rf;
    logic        we;
    logic [29:0] ma;
    logic [3:0]  be;
    logic [31:0] wd;

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        addr          = '0;
        wdata         = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        is_LB_SB      = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req",    bus.mem_req,   0);
        checkOutput("rst_we",     bus.mem_we,    0);
        checkOutput("rst_addr",   bus.mem_addr,  0);
        checkOutput("rst_be",     bus.mem_be,    0);
        checkOutput("rst_wdata",  bus.mem_wdata, 0);
        checkOutput("rst_freeze", freeze,        0);
        checkOutput("rst_dout",   cache_data_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold load miss, ack on third request cycle
        applyStimulus(1, 0, 0, 32'h100, 32'h0);
        service("lw100_miss", 3, 32'h11223344, fc, rf, we, ma, be, wd);
        checkOutput("lw100_freeze", fc, 4);
        checkOutput("lw100_we",     we, 0);
        checkOutput("lw100_addr",   ma, 30'h40);
        checkOutput("lw100_dout",   cache_data_out, 32'h11223344);
        checkOutput("done_req",     bus.mem_req, 0);

        // Same load still in MEM after DONE now hits
        applyStimulus(1, 0, 0, 32'h100, 32'h0);
        service("lw100_hit", 1, 32'h0, fc, rf, we, ma, be, wd);
        checkOutput("lw100_hit_freeze", fc, 0);
        checkOutput("lw100_hit_dout",   cache_data_out, 32'h11223344);

        // Byte store hit into lane 2
        applyStimulus(0, 1, 1, 32'h102, 32'h5555AA55);
        service("sb102", 2, 32'h0, fc, rf, we, ma, be, wd);
        checkOutput("sb102_freeze", fc, 3);
        checkOutput("sb102_we",     we, 1);
        checkOutput("sb102_be",     be, 4'b0100);
        checkOutput("sb102_addr",   ma, 30'h40);
        checkOutput("sb102_wdata",  wd, 32'h5555AA55);
        checkOutput("sb102_dout",   cache_data_out, 0);

        applyStimulus(1, 0, 0, 32'h100, 32'h0);
        service("lw100_after_sb", 1, 32'h0, fc, rf, we, ma, be, wd);
        checkOutput("lw100_sb_freeze", fc, 0);
        checkOutput("lw100_sb_dout",   cache_data_out, 32'h1122AA44);

        // Word store miss, ack in first request cycle
        applyStimulus(0, 1, 0, 32'h2000, 32'hDEADBEEF);
        service("sw2000", 1, 32'h0, fc, rf, we, ma, be, wd);
        checkOutput("sw2000_freeze", fc, 2);
        checkOutput("sw2000_we",     we, 1);
        checkOutput("sw2000_be",     be, 4'hF);
        checkOutput("sw2000_addr",   ma, 30'h800);

        applyStimulus(1, 0, 0, 32'h2000, 32'h0);
        service("lw2000", 2, 32'h01020304, fc, rf, we, ma, be, wd);
        checkOutput("lw2000_freeze", fc, 3);
        checkOutput("lw2000_we",     we, 0);
        checkOutput("lw2000_addr",   ma, 30'h800);
        checkOutput("lw2000_dout",   cache_data_out, 32'h01020304);

        // Conflict on index 0, with back-to-back misses after each DONE
        applyStimulus(1, 0, 0, 32'h0, 32'h0);
        service("lw0_a", 1, 32'hA1A2A3A4, fc, rf, we, ma, be, wd);
        checkOutput("lw0_a_freeze", fc, 2);
        checkOutput("lw0_a_dout",   cache_data_out, 32'hA1A2A3A4);

        applyStimulus(1, 0, 0, 32'h400, 32'h0);
        service("lw400", 2, 32'hB1B2B3B4, fc, rf, we, ma, be, wd);
        checkOutput("lw400_freeze",    fc, 3);
        checkOutput("lw400_req_first", rf, 2);
        checkOutput("lw400_addr",      ma, 30'h100);
        checkOutput("lw400_dout",      cache_data_out, 32'hB1B2B3B4);

        applyStimulus(1, 0, 0, 32'h0, 32'h0);
        service("lw0_b", 1, 32'hC1C2C3C4, fc, rf, we, ma, be, wd);
        checkOutput("lw0_b_freeze",    fc, 2);
        checkOutput("lw0_b_req_first", rf, 2);
        checkOutput("lw0_b_dout",      cache_data_out, 32'hC1C2C3C4);

        // Reset in the middle of a fill, then a late ack
        applyStimulus(1, 0, 0, 32'h3000, 32'h0);
        @(negedge clk);
        checkOutput("midfill_freeze0", freeze, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midfill_req", bus.mem_req, 1);
        rst      = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        checkOutput("postrst_req",    bus.mem_req, 0);
        checkOutput("postrst_freeze", freeze, 0);
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("lateack_req",    bus.mem_req, 0);
        checkOutput("lateack_freeze", freeze, 0);

        applyStimulus(1, 0, 0, 32'h100, 32'h0);
        service("lw100_postrst", 1, 32'h99887766, fc, rf, we, ma, be, wd);
        checkOutput("lw100_postrst_freeze", fc, 2);
        checkOutput("lw100_postrst_dout",   cache_data_out, 32'h99887766);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
